// File: rtl/stream_out_pkg.sv
// Shared types and sizing helpers for the stream output serializer.
package stream_out_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_e;

  localparam logic HDR_MARK = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int nibbles(input int w);
    return w / 4;
  endfunction
endpackage

// File: rtl/stream_out_serializer_sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head word whenever not empty.
module sync_fifo
  import stream_out_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full_n,
  output logic         empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign full_n = (count != (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign wr_en  = push && full_n;
  assign rd_en  = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/stream_out_serializer.sv
// Per-channel FIFOs, round-robin arbiter and nibble serializer emitting
// {header, data nibbles MS-first} frames on a 4-bit valid/ready link.
module stream_out_serializer
  import stream_out_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic [NUM_CH-1:0]        ch_write,
  output logic [NUM_CH-1:0]        ch_full_n,
  input  logic                     data_ready,
  output logic [3:0]               data_out,
  output logic                     data_valid,
  output logic                     probe_out
);
  localparam int NIB   = nibbles(DATA_W);
  localparam int CNT_W = (clog2(NIB) > 0) ? clog2(NIB) : 1;
  localparam int IDX_W = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
  localparam int CW    = clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0][DATA_W-1:0] fifo_dout;
  logic [NUM_CH-1:0][CW-1:0]     fifo_cnt;
  logic [NUM_CH-1:0]             fifo_empty, pop, drop, ovf;

  state_e             state, state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   nib_cnt;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx, cand;
  logic [2:0]         ch_id;
  logic               gnt_vld, last_nib;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (ap_clk),
      .rst    (ap_rst),
      .push   (ch_write[k]),
      .pop    (pop[k]),
      .din    (ch_din[k*DATA_W +: DATA_W]),
      .dout   (fifo_dout[k]),
      .count  (fifo_cnt[k]),
      .full_n (ch_full_n[k]),
      .empty  (fifo_empty[k])
    );
    assign pop[k] = (state == IDLE) && gnt_vld && (gnt_idx == IDX_W'(k));

    always @(posedge ap_clk)
      if (!ap_rst) assert (fifo_cnt[k] <= CW'(FIFO_DEPTH));
  end

  // A write against a full FIFO is lost even if a pop frees a slot this cycle.
  assign drop = ch_write & ~ch_full_n;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ovf       <= '0;
      probe_out <= 1'b0;
    end else begin
      ovf       <= ovf | drop;
      probe_out <= |(ovf | drop);
    end
  end

  // First non-empty channel at or after rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!gnt_vld && !fifo_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign last_nib = (nib_cnt == CNT_W'(NIB - 1));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = HDR;
      HDR:     if (data_ready) state_nxt = DATA;
      DATA:    if (data_ready && last_nib) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_out   = 4'h0;
    data_valid = 1'b0;
    case (state)
      HDR: begin
        data_out   = {HDR_MARK, ch_id};
        data_valid = 1'b1;
      end
      DATA: begin
        data_out   = shreg[DATA_W-1 -: 4];
        data_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      shreg   <= '0;
      nib_cnt <= '0;
      rr_ptr  <= '0;
      ch_id   <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          shreg  <= fifo_dout[gnt_idx];
          ch_id  <= 3'(gnt_idx);
          rr_ptr <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        HDR:  if (data_ready) nib_cnt <= '0;
        DATA: if (data_ready) begin
          shreg   <= shreg << 4;
          nib_cnt <= nib_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_out_serializer.sv
// Directed bench for stream_out_serializer: frame format, RR order,
// backpressure, overflow, mid-frame reset and full push/pop collision.
module tb_stream_out_serializer;
  localparam int NUM_CH = 2, DATA_W = 32, FIFO_DEPTH = 8;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst;
  logic [NUM_CH*DATA_W-1:0] ch_din;
  logic [NUM_CH-1:0]        ch_write, ch_full_n;
  logic                     data_ready;
  logic [3:0]               data_out;
  logic                     data_valid, probe_out;

  int n_checks = 0;
  int n_fail   = 0;

  stream_out_serializer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ch_din     (ch_din),
    .ch_write   (ch_write),
    .ch_full_n  (ch_full_n),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .probe_out  (probe_out)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rdy;
    logic        exp_vld;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ap_rst     = 1'b1;
    ch_write   = '0;
    ch_din     = '0;
    data_ready = 1'b0;
    tick();
    tick();
    ap_rst = 1'b0;
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!data_valid && waited < 30) begin
      tick();
      waited++;
    end
    check("valid_timeout", data_valid, 1);
  endtask

  task automatic expect_frame(input int ch, input logic [31:0] w, output int waited);
    logic [3:0] hdr;
    hdr = 4'(8 + ch);
    wait_valid(waited);
    check($sformatf("hdr ch%0d w%0h", ch, w), data_out, hdr);
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("nib%0d w%0h", i, w), {data_valid, data_out}, {1'b1, w[31-4*i -: 4]});
      tick();
    end
  endtask

  task automatic no_extra_frame(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (data_valid) seen = 1'b1;
      tick();
    end
    check(name, seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] word;

    do_reset();
    check("rst data_valid", data_valid, 0);
    check("rst data_out", data_out, 0);
    check("rst probe_out", probe_out, 0);
    check("rst ch_full_n", ch_full_n, 2'b11);

    // Single word: header two cycles after the write, then DEADBEEF MS-first.
    word    = 32'hDEADBEEF;
    vecs[0] = '{1'b1, word, 1'b1, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h8};
    for (int i = 0; i < 8; i++) vecs[3+i] = '{1'b0, 32'h0, 1'b1, 1'b1, word[31-4*i -: 4]};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      ch_write[0]  = vecs[i].wr;
      ch_din[31:0] = vecs[i].din;
      data_ready   = vecs[i].rdy;
      check($sformatf("vec%0d valid", i), data_valid, vecs[i].exp_vld);
      check($sformatf("vec%0d out", i), data_out, vecs[i].exp_out);
      tick();
    end
    ch_write = '0;

    // Round-robin: two same-cycle writes twice, frames alternate ch0/ch1.
    do_reset();
    data_ready = 1'b1;
    ch_write   = 2'b11;
    ch_din     = {32'h22222222, 32'h11111111};
    tick();
    tick();
    ch_write = '0;
    for (int f = 0; f < 4; f++) begin
      expect_frame(f % 2, (f % 2 == 0) ? 32'h11111111 : 32'h22222222, w);
      if (f > 0) check($sformatf("rr gap f%0d", f), w, 1);
    end
    no_extra_frame("rr no_extra");

    // Backpressure on the 4th data nibble of a ch1 frame.
    do_reset();
    data_ready     = 1'b1;
    ch_write       = 2'b10;
    ch_din[63:32]  = 32'h12345678;
    tick();
    ch_write = '0;
    wait_valid(w);
    check("bp hdr", data_out, 4'h9);
    tick();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("bp pre%0d", i), {data_valid, data_out}, {1'b1, 4'(i)});
      tick();
    end
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp hold%0d", i), {data_valid, data_out}, {1'b1, 4'h4});
      tick();
    end
    data_ready = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      check($sformatf("bp post%0d", i), {data_valid, data_out}, {1'b1, 4'(i)});
      tick();
    end
    check("bp end", data_valid, 0);

    // Overflow: 10 writes with the link stalled; 9 absorbed, word 9 dropped.
    do_reset();
    data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch_write     = 2'b01;
      ch_din[31:0] = 32'(i);
      check($sformatf("ovf full_n w%0d", i), ch_full_n[0], (i < 9) ? 1'b1 : 1'b0);
      check($sformatf("ovf probe w%0d", i), probe_out, 0);
      tick();
    end
    ch_write = '0;
    check("ovf probe set", probe_out, 1);
    data_ready = 1'b1;
    for (int i = 0; i < 9; i++) expect_frame(0, 32'(i), w);
    no_extra_frame("ovf no_extra");
    check("ovf probe sticky", probe_out, 1);
    check("ovf full_n back", ch_full_n, 2'b11);

    // Reset mid-frame (probe_out is still 1 here) flushes queued words too.
    ch_write      = 2'b10;
    ch_din[63:32] = 32'hC0FFEE11;
    tick();
    ch_write = '0;
    wait_valid(w);
    check("mr hdr", data_out, 4'h9);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        ch_write     = 2'b01;
        ch_din[31:0] = 32'h55555555;
      end
      check($sformatf("mr nib%0d", i), data_out, (i == 0) ? 4'hC : (i == 1) ? 4'h0 : 4'hF);
      tick();
      ch_write = '0;
    end
    check("mr 5th nibble", {data_valid, data_out}, {1'b1, 4'hF});
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("mr valid", data_valid, 0);
    check("mr out", data_out, 0);
    check("mr probe", probe_out, 0);
    check("mr full_n", ch_full_n, 2'b11);
    no_extra_frame("mr flushed");
    ch_write      = 2'b10;
    ch_din[63:32] = 32'h0BADF00D;
    tick();
    ch_write = '0;
    expect_frame(1, 32'h0BADF00D, w);
    check("mr latency", w, 1);

    // Write into a full FIFO on the IDLE pop cycle is dropped.
    do_reset();
    data_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch_write     = 2'b01;
      ch_din[31:0] = 32'hA0 + 32'(i);
      tick();
    end
    ch_write = '0;
    check("pp full", ch_full_n[0], 0);
    check("pp probe pre", probe_out, 0);
    data_ready = 1'b1;
    expect_frame(0, 32'hA0, w);
    check("pp idle", data_valid, 0);
    check("pp idle full", ch_full_n[0], 0);
    ch_write     = 2'b01;
    ch_din[31:0] = 32'hEEEEEEEE;
    tick();
    ch_write = '0;
    check("pp probe set", probe_out, 1);
    for (int i = 1; i < 9; i++) expect_frame(0, 32'hA0 + 32'(i), w);
    no_extra_frame("pp no_extra");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_out_serializer.md
Name: stream_out_serializer

Overview:
- Synthesizable successor to the per-stream output loggers: captures NUM_CH kernel output streams (ap_fifo write side: din/write/full_n) on-chip.
- Buffers each stream in its own FIFO and arbitrates round-robin between streams.
- Serializes each word onto the 4-bit data_out/data_valid link of the board wrapper as a channel-tagged nibble frame.
- probe_out reports sticky overflow.
- Sits between the HLS top and the wrapper's pin-level output, replacing simulation-only $fwrite capture.

Parameters:
- NUM_CH, 2, number of captured output streams (1..8).
- DATA_W, 32, stream word width; multiple of 4.
- FIFO_DEPTH, 8, words per channel FIFO; power of two, >=2.

Ports:
- ap_clk  in  1  single clock, all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ch_din  in  NUM_CH*DATA_W  packed stream data; channel k at bits [k*DATA_W +: DATA_W].
- ch_write  in  NUM_CH  per-channel write strobe.
- ch_full_n  out  NUM_CH  per-channel not-full (ap_fifo semantics).
- data_ready  in  1  downstream accepts the current nibble.
- data_out  out  4  serial nibble.
- data_valid  out  1  data_out holds a valid nibble.
- probe_out  out  1  sticky OR of per-channel overflow flags.

Behaviour:
- Reset (ap_rst high at an edge): all FIFOs empty; ch_full_n = all 1; data_out = 0; data_valid = 0; probe_out = 0; RR pointer = channel 0; FSM = IDLE. Reset mid-frame aborts the frame with no partial completion; the first post-reset frame starts with a header.
- FIFO write: accepted when ch_write[k] && ch_full_n[k]. ch_full_n[k] = (count_k != FIFO_DEPTH), derived from the registered count.
- Write with full_n low: word is dropped and ovf[k] sets, even if a pop occurs in the same cycle. ovf clears only on reset. probe_out is registered and equals OR(ovf) one cycle after the offending write.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both take effect.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If any FIFO is non-empty, grant the first non-empty channel at or after the RR pointer (wrapping NUM_CH-1 -> 0).
  - Pop that word into the shift register, latch its channel id, set the RR pointer to grant+1 mod NUM_CH, and go to HDR.
  - data_valid = 0 in IDLE.
- HDR: data_out = {1'b1, ch_id[2:0]}; data_valid = 1. On data_ready go to DATA with nibble counter = 0.
- DATA:
  - data_out = current most-significant nibble of the shift register; data_valid = 1.
  - On data_ready, shift left 4 and increment the counter.
  - After nibble DATA_W/4-1 is accepted, go to IDLE.
- Hold rule: while data_valid && !data_ready, data_out and data_valid stay stable.
- Frame length: 1 + DATA_W/4 accepted nibbles (9 for DATA_W=32). With data_ready held high there is one idle cycle between frames (IDLE pop cycle).
- Latency: write to an empty FIFO with FSM in IDLE at cycle t gives the header on data_out at cycle t+2.
- One pop in flight plus FIFO_DEPTH buffered means FIFO_DEPTH+1 words can be absorbed per channel while data_ready = 0.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits; the nibble counter is sized for DATA_W/4.

Decomposition:
- Package stream_out_pkg:
  - FSM state enum (IDLE/HDR/DATA).
  - HDR_MARK = 1'b1.
  - NIBBLES = DATA_W/4 function.
  - clog2 helper.
- Sub-module sync_fifo (width DATA_W, depth FIFO_DEPTH, push/pop/count/full_n/empty), instantiated NUM_CH times by generate. Arbiter and serializer FSM stay in the top module.

Test Plan:
- Single word: ch0 writes 32'hDEADBEEF, data_ready = 1.
  - data_out sequence 8,D,E,A,D,B,E,E,F, data_valid high for 9 consecutive cycles.
  - Header appears 2 cycles after the write.
- Round-robin: ch0 writes 32'h11111111 and ch1 writes 32'h22222222 in the same cycle, then both again.
  - Headers in order 8,9,8,9.
  - Data nibbles match each source word.
- Backpressure: during the ch1 frame for 32'h12345678, drop data_ready for 3 cycles at the 4th data nibble.
  - data_out holds 4 and data_valid stays 1.
  - Frame resumes 5,6,7,8 with nothing lost or duplicated.
- Overflow: data_ready = 0, ch0 writes 10 consecutive words 0..9.
  - ch_full_n[0] drops after the 9th accepted word; word 9 is dropped.
  - probe_out = 1 next cycle.
  - After data_ready = 1, exactly 9 frames carry words 0..8, and probe_out stays 1.
- Reset mid-frame: assert ap_rst during the 5th nibble.
  - Next cycle data_valid = 0, probe_out = 0, ch_full_n = all 1.
  - A new write after reset produces a complete frame starting with its header.
- Full push/pop: FIFO full, data_ready = 1, write on the same cycle as the IDLE pop.
  - The write is dropped and ovf sets.
